// File: rtl/conv_psum_accumulator_if.sv
// Streaming bus between the MAC array and the channel accumulator.
// Carries bias_i only when CONV_ACC_BIAS_EN is defined.
interface conv_psum_accumulator_if #(
  parameter int NO = 4,
  parameter int AW = 20,
  parameter int PW = 32,
  parameter int OW = 8
);
  logic              vld_i;
  logic [NO*AW-1:0]  acc_i;
`ifdef CONV_ACC_BIAS_EN
  logic [NO*PW-1:0]  bias_i;
`endif
  logic              vld_o;
  logic [NO*OW-1:0]  dout;

`ifdef CONV_ACC_BIAS_EN
  modport master (output vld_i, acc_i, bias_i, input vld_o, dout);
  modport slave  (input vld_i, acc_i, bias_i, output vld_o, dout);
`else
  modport master (output vld_i, acc_i, input vld_o, dout);
  modport slave  (input vld_i, acc_i, output vld_o, dout);
`endif
endinterface

// File: rtl/conv_psum_accumulator.sv
// Per-pixel channel accumulation, rounded descale, ReLU/signed saturation and frame counting.
// Optional per-lane bias at channel 0 is enabled by defining CONV_ACC_BIAS_EN.
module conv_psum_accumulator #(
  parameter int NO = 4,
  parameter int AW = 20,
  parameter int PW = 32,
  parameter int OW = 8,
  parameter int CW = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    clear,
  input  logic [CW-1:0]           cfg_num_chn,
  input  logic [31:0]             cfg_num_pix,
  input  logic [4:0]              cfg_shift,
  input  logic                    cfg_relu,
  conv_psum_accumulator_if.slave  bus,
  output logic [CW-1:0]           chn_idx_o,
  output logic [31:0]             pix_cnt_o,
  output logic                    frame_done
);

  localparam logic signed [PW:0] U_MAX = (PW+1)'((64'd1 << OW) - 64'd1);
  localparam logic signed [PW:0] S_MAX = (PW+1)'((64'd1 << (OW-1)) - 64'd1);
  localparam logic signed [PW:0] S_MIN = ~S_MAX;

  logic signed [PW-1:0] psum_reg [NO];
  logic [CW-1:0]        chn_idx_reg;
  logic [31:0]          pix_cnt_reg;
  logic                 vld_o_reg;
  logic                 frame_done_reg;
  logic [NO*OW-1:0]     dout_reg;

  logic [NO*PW-1:0]     sum_next;
  logic [NO*OW-1:0]     lane_out;
  logic [CW-1:0]        num_chn_eff;
  logic [31:0]          num_pix_eff;
  logic                 first_chn;
  logic                 last_chn;
  logic                 last_pix;
  logic [PW:0]          rnd_val;

  assign num_chn_eff = (cfg_num_chn == '0) ? CW'(1) : cfg_num_chn;
  assign num_pix_eff = (cfg_num_pix == '0) ? 32'd1 : cfg_num_pix;
  assign first_chn   = (chn_idx_reg == '0);
  assign last_chn    = (chn_idx_reg == num_chn_eff - CW'(1));
  assign last_pix    = (pix_cnt_reg == num_pix_eff - 32'd1);
  assign rnd_val     = (cfg_shift == 5'd0) ? '0 : ({{PW{1'b0}}, 1'b1} << (cfg_shift - 5'd1));

  for (genvar gi = 0; gi < NO; gi++) begin : g_lane
    logic signed [PW-1:0] acc_ext;
    logic signed [PW-1:0] base;
    logic signed [PW-1:0] sum_v;
    logic signed [PW:0]   rnd_sum;
    logic signed [PW:0]   shifted;
    logic [OW-1:0]        sat_v;

    assign acc_ext = {{(PW-AW){bus.acc_i[gi*AW+AW-1]}}, bus.acc_i[gi*AW +: AW]};
`ifdef CONV_ACC_BIAS_EN
    assign base = first_chn ? bus.bias_i[gi*PW +: PW] : psum_reg[gi];
`else
    assign base = first_chn ? '0 : psum_reg[gi];
`endif
    assign sum_v = base + acc_ext;

    // One extra bit of headroom so the half-LSB rounding add never wraps.
    assign rnd_sum = {sum_v[PW-1], sum_v} + rnd_val;
    assign shifted = rnd_sum >>> cfg_shift;

    always_comb begin
      sat_v = shifted[OW-1:0];
      if (cfg_relu) begin
        if (shifted[PW])
          sat_v = '0;
        else if (shifted > U_MAX)
          sat_v = '1;
      end else begin
        if (shifted > S_MAX)
          sat_v = {1'b0, {(OW-1){1'b1}}};
        else if (shifted < S_MIN)
          sat_v = {1'b1, {(OW-1){1'b0}}};
      end
    end

    assign sum_next[gi*PW +: PW] = sum_v;
    assign lane_out[gi*OW +: OW] = sat_v;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < NO; k++) psum_reg[k] <= '0;
      chn_idx_reg    <= '0;
      pix_cnt_reg    <= '0;
      vld_o_reg      <= 1'b0;
      frame_done_reg <= 1'b0;
      dout_reg       <= '0;
    end else if (clear) begin
      for (int k = 0; k < NO; k++) psum_reg[k] <= '0;
      chn_idx_reg    <= '0;
      pix_cnt_reg    <= '0;
      vld_o_reg      <= 1'b0;
      frame_done_reg <= 1'b0;
      dout_reg       <= '0;
    end else begin
      vld_o_reg      <= 1'b0;
      frame_done_reg <= 1'b0;
      if (bus.vld_i) begin
        for (int k = 0; k < NO; k++) psum_reg[k] <= sum_next[k*PW +: PW];
        if (last_chn) begin
          chn_idx_reg <= '0;
          vld_o_reg   <= 1'b1;
          dout_reg    <= lane_out;
          if (last_pix) begin
            pix_cnt_reg    <= '0;
            frame_done_reg <= 1'b1;
          end else begin
            pix_cnt_reg <= pix_cnt_reg + 32'd1;
          end
        end else begin
          chn_idx_reg <= chn_idx_reg + CW'(1);
        end
      end
    end
  end

  assign bus.vld_o  = vld_o_reg;
  assign bus.dout   = dout_reg;
  assign chn_idx_o  = chn_idx_reg;
  assign pix_cnt_o  = pix_cnt_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_conv_psum_accumulator.sv
// Directed + randomised bench for conv_psum_accumulator: a behavioural model pushes
// expected pixels to a scoreboard queue, a negedge monitor pops and compares them.
module tb_conv_psum_accumulator;
  localparam int NO = 4;
  localparam int AW = 20;
  localparam int PW = 32;
  localparam int OW = 8;
  localparam int CW = 16;

  logic          clk;
  logic          rstn;
  logic          clear;
  logic [CW-1:0] cfg_num_chn;
  logic [31:0]   cfg_num_pix;
  logic [4:0]    cfg_shift;
  logic          cfg_relu;
  logic [CW-1:0] chn_idx_o;
  logic [31:0]   pix_cnt_o;
  logic          frame_done;

  conv_psum_accumulator_if #(.NO(NO), .AW(AW), .PW(PW), .OW(OW)) bus ();

  conv_psum_accumulator #(.NO(NO), .AW(AW), .PW(PW), .OW(OW), .CW(CW)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .clear       (clear),
    .cfg_num_chn (cfg_num_chn),
    .cfg_num_pix (cfg_num_pix),
    .cfg_shift   (cfg_shift),
    .cfg_relu    (cfg_relu),
    .bus         (bus.slave),
    .chn_idx_o   (chn_idx_o),
    .pix_cnt_o   (pix_cnt_o),
    .frame_done  (frame_done)
  );

  typedef struct {
    logic [NO*OW-1:0] dout;
    logic [31:0]      pix;
    logic             fd;
  } exp_t;

  exp_t   sb_q[$];
  int     n_vec = 0;
  int     n_err = 0;
  int     m_chn, m_pix, m_nchn, m_npix, m_shift;
  bit     m_relu;
  longint m_sum[NO];
  int     bias_val;
  logic [NO*OW-1:0] last_dout;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [OW-1:0] post(input longint s, input int sh, input bit relu);
    longint r;
    r = s + ((sh > 0) ? (longint'(1) << (sh - 1)) : longint'(0));
    r = r >>> sh;
    if (relu) begin
      if (r < 0) return '0;
      if (r > 255) return 8'hFF;
    end else begin
      if (r > 127) return 8'h7F;
      if (r < -128) return 8'h80;
    end
    return r[OW-1:0];
  endfunction

  task automatic set_cfg(input int c, input int p, input int s, input bit r);
    cfg_num_chn = CW'(c);
    cfg_num_pix = 32'(p);
    cfg_shift   = 5'(s);
    cfg_relu    = r;
    m_nchn = (c == 0) ? 1 : c;
    m_npix = (p == 0) ? 1 : p;
    m_shift = s;
    m_relu  = r;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One input channel on all lanes; the model folds it in and predicts the pixel when complete.
  task automatic chan(input int a0, input int a1, input int a2, input int a3);
    int   a[NO];
    exp_t e;
    a = '{a0, a1, a2, a3};
    bus.vld_i = 1'b1;
    for (int k = 0; k < NO; k++) begin
      bus.acc_i[k*AW +: AW] = AW'(a[k]);
`ifdef CONV_ACC_BIAS_EN
      bus.bias_i[k*PW +: PW] = PW'(bias_val);
      m_sum[k] = ((m_chn == 0) ? longint'(bias_val) : m_sum[k]) + longint'(a[k]);
`else
      m_sum[k] = ((m_chn == 0) ? longint'(0) : m_sum[k]) + longint'(a[k]);
`endif
    end
    if (m_chn == m_nchn - 1) begin
      for (int k = 0; k < NO; k++) e.dout[k*OW +: OW] = post(m_sum[k], m_shift, m_relu);
      if (m_pix == m_npix - 1) begin
        m_pix = 0;
        e.fd  = 1'b1;
      end else begin
        m_pix++;
        e.fd = 1'b0;
      end
      e.pix = 32'(m_pix);
      sb_q.push_back(e);
      m_chn = 0;
    end else begin
      m_chn++;
    end
    @(posedge clk);
    #1;
    bus.vld_i = 1'b0;
    chk("chn_idx", 64'(chn_idx_o), 64'(m_chn));
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    m_chn = 0;
    m_pix = 0;
    chk("clear_chn_idx", 64'(chn_idx_o), 64'd0);
    chk("clear_dout", 64'(bus.dout), 64'd0);
    chk("clear_pix_cnt", 64'(pix_cnt_o), 64'd0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    m_chn = 0;
    m_pix = 0;
    chk("rst_chn_idx", 64'(chn_idx_o), 64'd0);
    chk("rst_dout", 64'(bus.dout), 64'd0);
    chk("rst_pix_cnt", 64'(pix_cnt_o), 64'd0);
    chk("rst_vld_o", 64'(bus.vld_o), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (rstn === 1'b1) begin
      if (bus.vld_o === 1'b1) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_vld_o", 64'(bus.vld_o), 64'd0);
        end else begin
          e = sb_q.pop_front();
          last_dout = e.dout;
          $display("pixel dout=%08h pix_cnt=%0d frame_done=%0b", bus.dout, pix_cnt_o, frame_done);
          chk("dout", 64'(bus.dout), 64'(e.dout));
          chk("pix_cnt", 64'(pix_cnt_o), 64'(e.pix));
          chk("frame_done", 64'(frame_done), 64'(e.fd));
        end
      end else begin
        chk("frame_done_idle", 64'(frame_done), 64'd0);
      end
    end
  end

  initial begin
    int guard;
    rstn = 1'b0;
    clear = 1'b0;
    bus.vld_i = 1'b0;
    bus.acc_i = '0;
`ifdef CONV_ACC_BIAS_EN
    bus.bias_i = '0;
`endif
    bias_val = 0;
    m_chn = 0;
    m_pix = 0;
    last_dout = '0;
    for (int k = 0; k < NO; k++) m_sum[k] = 0;
    set_cfg(3, 1000, 7, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // T1: three channels back-to-back, lane0 sums to 600 -> 5
    chan(100, 5000, -300, 0);
    chan(200, 5000, -300, 0);
    chan(300, 5000, -300, 0);
    idle(2);

    // T2: single-channel saturation in both modes
    set_cfg(1, 1000, 7, 1'b1);
    chan(40000, -5000, 0, 1);
    set_cfg(1, 1000, 7, 1'b0);
    chan(40000, -5000, 0, 1);
    idle(2);

    // T3: gaps between channels; dout must hold between pulses
    set_cfg(3, 1000, 7, 1'b1);
    chk("t3_chn_idx_start", 64'(chn_idx_o), 64'd0);
    chan(100, 1, 2, 3);
    idle(2);
    chan(200, 1, 2, 3);
    idle(2);
    chan(300, 1, 2, 3);
    idle(3);
    chk("dout_hold", 64'(bus.dout), 64'(last_dout));

    // T4: 4-pixel frame, then into the next frame
    do_clear();
    set_cfg(2, 4, 0, 1'b0);
    for (int p = 0; p < 6; p++) begin
      chan(p * 3, -p, 60, -70);
      chan(p, 2 * p, 70, -60);
    end
    idle(2);

    // T5: clear and reset mid-pixel discard the partial sum
    set_cfg(3, 1000, 0, 1'b0);
    chan(999, 999, 999, 999);
    do_clear();
    chan(10, 10, 10, 10);
    chan(10, 10, 10, 10);
    chan(10, 10, 10, 10);
    idle(2);
    chan(999, 999, 999, 999);
    do_reset();
    chan(10, 10, 10, 10);
    chan(10, 10, 10, 10);
    chan(10, 10, 10, 10);
    idle(2);

    // T6: bias at channel 0 (ignored when the feature is not built in)
    set_cfg(1, 1000, 7, 1'b1);
    bias_val = 128;
    chan(0, 0, 0, 0);
    bias_val = 0;
    idle(2);

    // Boundaries: zero counts mean one, extreme shifts, negative clamp
    do_clear();
    set_cfg(0, 0, 3, 1'b0);
    chan(-2000, 2000, 7, -9);
    chan(-4, 4, 1000, -1020);
    set_cfg(1, 1000, 31, 1'b0);
    chan(524287, -524288, 1, -1);
    set_cfg(1, 1000, 0, 1'b1);
    chan(255, 256, -1, 0);
    set_cfg(1, 1000, 1, 1'b0);
    chan(3, -3, 1, -1);
    idle(2);

    // Random pixels over varied configurations
    for (int p = 0; p < 8; p++) begin
      set_cfg($urandom_range(4, 1), 1000, $urandom_range(12, 0), 1'($urandom_range(1, 0)));
      for (int c = 0; c < m_nchn; c++) begin
        chan($urandom_range(200000, 0) - 100000, $urandom_range(200000, 0) - 100000,
             $urandom_range(2000, 0) - 1000, $urandom_range(60000, 0) - 30000);
        if ($urandom_range(1, 0) == 1) idle(1);
      end
    end

    guard = 0;
    while (sb_q.size() != 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #1;
    chk("drain", 64'(sb_q.size()), 64'd0);
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
